uart_frame_unpacker: RTL and testbench

Downstream consumer of the 8-bit UART receiver: takes each received byte, parses it against a fixed frame format, assembles little-endian payload words and buffers them in an internal FIFO. Frames are written speculatively and become visible at the output only after the checksum passes. A failed frame is rolled back atomically. The output is a valid/ready word stream that feeds the network input loader.

---
 rtl/uart_frame_unpacker.sv | 193 +++++++++++++++++++
 tb/tb_uart_frame_unpacker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_unpacker.sv
// UART byte-stream frame parser feeding a speculative-commit word FIFO.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_frame_unpacker #(
  parameter int          WORD_BYTES     = 2,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          MAX_LEN        = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 57280
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  output logic [8*WORD_BYTES-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          frame_ok,
  output logic                          frame_err,
  output logic [1:0]                    err_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state_dbg
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t          state, state_n;
  logic            rx_d1, rx_d2, strobe;
  logic [PW-1:0]   wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr;
  logic [7:0]      chk, chk_n, words_left, words_left_n;
  logic [1:0]      byte_idx, byte_idx_n;
  logic [WW-1:0]   word_buf, word_n, word_ins;
  logic            ok_n, err_n, fail, mem_we, mem_last_w, timeout, len_bad;
  logic [1:0]      err_code_n, fail_code;
  logic [WW-1:0]   mem_data [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];

  assign strobe     = rx_d1 & ~rx_d2;
  assign out_valid  = (rd_ptr != commit_ptr);
  assign out_data   = mem_data[rd_ptr[AW-1:0]];
  assign out_last   = out_valid & mem_last[rd_ptr[AW-1:0]];
  assign fifo_level = commit_ptr - rd_ptr;
  assign state_dbg  = state;

  // Free space is judged on committed occupancy; wr_ptr equals commit_ptr here.
  assign len_bad = (rx_data == 8'd0) || (int'(rx_data) > MAX_LEN) ||
                   (int'(rx_data) > FIFO_DEPTH - int'(fifo_level));

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              tmo_cnt <= '0;
    else if (state == S_HUNT || strobe)   tmo_cnt <= '0;
    else                                  tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign timeout = (state != S_HUNT) && !strobe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    word_ins = word_buf;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_idx == 2'(i)) word_ins[i*8 +: 8] = rx_data;
    end
  end

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    chk_n        = chk;
    words_left_n = words_left;
    byte_idx_n   = byte_idx;
    word_n       = word_buf;
    ok_n         = 1'b0;
    err_n        = 1'b0;
    err_code_n   = err_code;
    fail         = 1'b0;
    fail_code    = 2'd0;
    mem_we       = 1'b0;
    mem_last_w   = 1'b0;
    case (state)
      S_HUNT: begin
        if (strobe && rx_data == SYNC_BYTE) state_n = S_LEN;
      end
      S_LEN: begin
        if (strobe) begin
          if (len_bad) begin
            fail      = 1'b1;
            fail_code = 2'd1;
          end else begin
            words_left_n = rx_data;
            chk_n        = rx_data;
            byte_idx_n   = 2'd0;
            state_n      = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (strobe) begin
          chk_n  = chk ^ rx_data;
          word_n = word_ins;
          if (byte_idx == LAST_LANE) begin
            mem_we       = 1'b1;
            mem_last_w   = (words_left == 8'd1);
            wr_ptr_n     = wr_ptr + PW'(1);
            byte_idx_n   = 2'd0;
            words_left_n = words_left - 8'd1;
            if (words_left == 8'd1) state_n = S_CHK;
          end else begin
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
      S_CHK: begin
        if (strobe) begin
          if (rx_data == chk) begin
            commit_ptr_n = wr_ptr;
            ok_n         = 1'b1;
            err_code_n   = 2'd0;
            state_n      = S_HUNT;
          end else begin
            fail      = 1'b1;
            fail_code = 2'd2;
          end
        end
      end
      default: state_n = S_HUNT;
    endcase
    // Every error path rolls back to the last committed word in one step.
    if (timeout) begin
      fail      = 1'b1;
      fail_code = 2'd3;
    end
    if (fail) begin
      wr_ptr_n   = commit_ptr;
      err_n      = 1'b1;
      err_code_n = fail_code;
      state_n    = S_HUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d1      <= 1'b0;
      rx_d2      <= 1'b0;
      state      <= S_HUNT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      chk        <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      rx_d1      <= rx_done;
      rx_d2      <= rx_d1;
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      chk        <= chk_n;
      words_left <= words_left_n;
      byte_idx   <= byte_idx_n;
      word_buf   <= word_n;
      frame_ok   <= ok_n;
      frame_err  <= err_n;
      err_code   <= err_code_n;
      if (out_valid && out_ready) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_data[wr_ptr[AW-1:0]] <= word_ins;
      mem_last[wr_ptr[AW-1:0]] <= mem_last_w;
    end
  end

endmodule

// File: tb/tb_uart_frame_unpacker.sv
// Directed bench for uart_frame_unpacker: frame-level model plus per-cycle output compare.
// Handshake: a word moves when out_valid and out_ready are both high at a rising edge.
module tb_uart_frame_unpacker;
  localparam int WB = 2;
  localparam int DEPTH = 16;
  localparam int MAXL = 8;
  localparam int EW = 8 * WB + 1;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef FRAME_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 57280;
`endif

  logic clk, rst, rx_done, out_ready, out_valid, out_last, frame_ok, frame_err;
  logic [7:0] rx_data;
  logic [8*WB-1:0] out_data;
  logic [1:0] err_code, state_dbg;
  logic [4:0] fifo_level;

  uart_frame_unpacker #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL),
                        .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .fifo_level(fifo_level), .state_dbg(state_dbg));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] stg_q[$];
  logic [EW-1:0] acc_log[$];
  bit            pend_ok[$];
  logic [1:0]    pend_code[$];
  int            pend_n[$];
  logic [1:0]    exp_code = 2'd0;
  bit            mon_en = 1'b0;
  bit            m_ok;
  int            m_n;
  int            err_cyc = 0;
  int            t_strobe = 0;
  logic [7:0]    pl[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: wait expired, got nothing, expected event (cycle %0d)", name, cyc);
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_ok || frame_err) begin
        err_cyc = cyc;
        if (pend_ok.size() == 0) begin
          check("spurious_frame_event", {30'd0, frame_ok, frame_err}, 32'd0);
        end else begin
          m_ok = pend_ok.pop_front();
          exp_code = pend_code.pop_front();
          m_n = pend_n.pop_front();
          check("frame_kind", {30'd0, frame_ok, frame_err}, {30'd0, m_ok, !m_ok});
          if (m_ok) repeat (m_n) exp_q.push_back(stg_q.pop_front());
        end
      end
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      check("err_code", 32'(err_code), 32'(exp_code));
      if (out_valid && exp_q.size() != 0) begin
        check("head_word", 32'({out_last, out_data}), 32'(exp_q[0]));
        if (out_ready) begin
          acc_log.push_back({out_last, out_data});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    t_strobe = cyc + 2;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_outcome(input int limit);
    for (int i = 0; i < limit && pend_ok.size() != 0; i++) @(negedge clk);
    if (pend_ok.size() != 0) begin
      bound_fail("frame_outcome");
      pend_ok.delete(); pend_code.delete(); pend_n.delete(); stg_q.delete();
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) bound_fail("fifo_drain");
  endtask

  // Frame model: outcome follows from LEN, free space and the XOR checksum.
  task automatic send_frame(input int len, input logic [7:0] chk_flip, input int hold,
                            input int stall);
    int lvl;
    bit bad_len;
    logic [7:0] c;
    logic [EW-1:0] w;
    lvl = exp_q.size();
    bad_len = (len == 0) || (len > MAXL) || (len > DEPTH - lvl);
    if (bad_len) begin
      pend_ok.push_back(1'b0); pend_code.push_back(2'd1); pend_n.push_back(0);
    end else if (chk_flip != 8'd0) begin
      pend_ok.push_back(1'b0); pend_code.push_back(2'd2); pend_n.push_back(0);
    end else begin
      pend_ok.push_back(1'b1); pend_code.push_back(2'd0); pend_n.push_back(len);
      for (int k = 0; k < len; k++) begin
        w = '0;
        for (int b = 0; b < WB; b++) w[b*8 +: 8] = pl[k*WB + b];
        w[EW-1] = (k == len - 1);
        stg_q.push_back(w);
      end
    end
    drive_byte(SYNC, hold);
    drive_byte(8'(len), hold);
    if (!bad_len) begin
      c = 8'(len);
      for (int i = 0; i < len * WB; i++) begin
        c = c ^ pl[i];
        drive_byte(pl[i], hold);
        if (i == 0) repeat (stall) @(negedge clk);
      end
      drive_byte(c ^ chk_flip, hold);
    end
    wait_outcome(60);
  endtask

  task automatic fill_pl(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) pl[i] = base + 8'(i * 8'h13);
  endtask

  int base_log;

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    set_ready(1'b1);

    // good frame A5 02 34 12 78 56 0A
    pl[0] = 8'h34; pl[1] = 8'h12; pl[2] = 8'h78; pl[3] = 8'h56;
    send_frame(2, 8'h00, 1, 0);
    wait_drain();
    check("lit_word0", 32'(acc_log.size() > 0 ? acc_log[0] : '0), 32'h0_1234);
    check("lit_word1", 32'(acc_log.size() > 1 ? acc_log[1] : '0), 32'h1_5678);

    // bad checksum, then a good frame
    send_frame(2, 8'h01, 1, 0);
    check("badchk_code", 32'(err_code), 32'd2);
    check("badchk_level", 32'(fifo_level), 32'd0);
    fill_pl(6, 8'h40);
    send_frame(3, 8'h00, 1, 0);
    wait_drain();

    // length errors
    send_frame(0, 8'h00, 1, 0);
    check("len0_state_hunt", 32'(state_dbg), 32'd0);
    send_frame(9, 8'h00, 1, 0);
    check("len9_code", 32'(err_code), 32'd1);
    check("len9_state_hunt", 32'(state_dbg), 32'd0);
    fill_pl(2, 8'hA5);
    send_frame(1, 8'h00, 1, 0);
    wait_drain();

    // fill to capacity, overflow reject, drain across wrap
    set_ready(1'b0);
    base_log = acc_log.size();
    fill_pl(16, 8'h01);
    send_frame(8, 8'h00, 1, 0);
    fill_pl(16, 8'h80);
    send_frame(8, 8'h00, 1, 0);
    check("full_level", 32'(fifo_level), 32'd16);
    fill_pl(2, 8'h55);
    send_frame(1, 8'h00, 1, 0);
    check("full_reject_code", 32'(err_code), 32'd1);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) set_ready(1'($urandom_range(0, 1)));
    set_ready(1'b1);
    wait_drain();
    check("drain_count", 32'(acc_log.size() - base_log), 32'd16);

    // long rx_done pulses with noise before sync
    drive_byte(8'h00, 5);
    drive_byte(8'hFF, 5);
    fill_pl(4, 8'h21);
    send_frame(2, 8'h00, 5, 0);
    wait_drain();

`ifdef FRAME_TIMEOUT_EN
    pend_ok.push_back(1'b0); pend_code.push_back(2'd3); pend_n.push_back(0);
    drive_byte(SYNC, 1);
    drive_byte(8'h02, 1);
    drive_byte(8'h34, 1);
    wait_outcome(200);
    check("timeout_latency", 32'(err_cyc - t_strobe), 32'd100);
    check("timeout_state_hunt", 32'(state_dbg), 32'd0);
`else
    fill_pl(4, 8'h66);
    send_frame(2, 8'h00, 1, 300);
    wait_drain();
`endif

    // asynchronous reset in the middle of a frame
    set_ready(1'b0);
    fill_pl(2, 8'h0C);
    send_frame(1, 8'h00, 1, 0);
    send_frame(1, 8'h03, 1, 0);
    drive_byte(SYNC, 1);
    drive_byte(8'h02, 1);
    drive_byte(8'h11, 1);
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_fifo_level", 32'(fifo_level), 32'd0);
    check("midrst_err_code", 32'(err_code), 32'd0);
    check("midrst_frame_ok", 32'(frame_ok), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    exp_q.delete(); stg_q.delete(); pend_ok.delete(); pend_code.delete(); pend_n.delete();
    exp_code = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    set_ready(1'b1);
    fill_pl(4, 8'h3C);
    send_frame(2, 8'h00, 1, 0);
    wait_drain();

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
